// File: rtl/composite_video_gen.sv
// Composite video timing and sample generator.
// NTSC or PAL raster from one pixel clock: sync, blanking, NTSC colour burst
// and luma from an external pixel source or built-in test patterns.
// All picture outputs are registered together so sample_o and its flags line up.
module composite_video_gen #(
    parameter int DAC_W       = 12,
    parameter int PIX_W       = 8,
    parameter int SYNC_LVL    = 0,
    parameter int BLACK_LVL   = 'h4CD,
    parameter int WHITE_LVL   = 'hFFF,
    parameter int BURST_AMP   = 'h0F0,
    parameter int INVERT      = 1,
    parameter int HS_START    = 22,
    parameter int HS_LEN      = 67,
    parameter int BURST_START = 89,
    parameter int BURST_LEN   = 36,
    parameter int ACT_START   = 157,
    parameter int ACT_LEN     = 752,
    parameter int N_LINE_LEN  = 910,
    parameter int N_LINES     = 262,
    parameter int N_VS_START  = 249,
    parameter int N_VS_END    = 255,
    parameter int N_ACT_LINES = 245,
    parameter int P_LINE_LEN  = 916,
    parameter int P_LINES     = 312,
    parameter int P_VS_START  = 300,
    parameter int P_VS_END    = 305,
    parameter int P_ACT_LINES = 288
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pal_sel_i,
    input  logic             color_en_i,
    input  logic [2:0]       src_sel_i,
    output logic             pix_req_o,
    output logic [9:0]       pix_x_o,
    output logic [8:0]       pix_y_o,
    input  logic [PIX_W-1:0] pix_luma_i,
    output logic [DAC_W-1:0] sample_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             active_o,
    output logic             frame_o
);

    localparam int BW = PIX_W + 3;
    localparam int SH = DAC_W - PIX_W;
    localparam int FULL = (1 << PIX_W) - 1;

    localparam logic [DAC_W-1:0] SYNC_C     = DAC_W'(SYNC_LVL);
    localparam logic [DAC_W-1:0] BLACK_C    = DAC_W'(BLACK_LVL);
    localparam logic [DAC_W-1:0] WHITE_C    = DAC_W'(WHITE_LVL);
    localparam logic [DAC_W-1:0] BURST_HI   = DAC_W'(BLACK_LVL + BURST_AMP);
    localparam logic [DAC_W-1:0] BURST_LO   = DAC_W'(BLACK_LVL - BURST_AMP);
    localparam logic [DAC_W-1:0] SAMPLE_RST = (INVERT != 0) ? '1 : '0;
    localparam logic [DAC_W:0]   BLACK_X    = (DAC_W+1)'(BLACK_LVL);
    localparam logic [DAC_W:0]   WHITE_X    = (DAC_W+1)'(WHITE_LVL);

    localparam logic [9:0] HS_S   = 10'(HS_START);
    localparam logic [9:0] HS_E   = 10'(HS_START + HS_LEN);
    localparam logic [9:0] BU_S   = 10'(BURST_START);
    localparam logic [9:0] BU_E   = 10'(BURST_START + BURST_LEN);
    localparam logic [9:0] ACT_S  = 10'(ACT_START);
    localparam logic [9:0] ACT_E  = 10'(ACT_START + ACT_LEN);
    localparam logic [9:0] REQ_S  = 10'(ACT_START - 1);
    localparam logic [9:0] REQ_E  = 10'(ACT_START - 1 + ACT_LEN);
    localparam logic [9:0] N_HLST = 10'(N_LINE_LEN - 1);
    localparam logic [9:0] P_HLST = 10'(P_LINE_LEN - 1);
    // On vsync lines the sync pulse runs long: it ends HS_LEN before the next hsync would start.
    localparam logic [9:0] N_VSSE = 10'(N_LINE_LEN - HS_LEN + HS_START);
    localparam logic [9:0] P_VSSE = 10'(P_LINE_LEN - HS_LEN + HS_START);
    localparam logic [8:0] N_LLST = 9'(N_LINES - 1);
    localparam logic [8:0] P_LLST = 9'(P_LINES - 1);
    localparam logic [8:0] N_VS_S = 9'(N_VS_START);
    localparam logic [8:0] N_VS_E = 9'(N_VS_END);
    localparam logic [8:0] P_VS_S = 9'(P_VS_START);
    localparam logic [8:0] P_VS_E = 9'(P_VS_END);
    localparam logic [8:0] N_ACTL = 9'(N_ACT_LINES);
    localparam logic [8:0] P_ACTL = 9'(P_ACT_LINES);

    logic [9:0]       hpos_q, hpos_d;
    logic [8:0]       line_q, line_d;
    logic             pal_q, pal_d;
    logic [DAC_W-1:0] sample_q, sample_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             frame_q, frame_d;

    logic [9:0]       hpos_last, vs_sync_e;
    logic [8:0]       line_last, vs_s, vs_e, act_lines;
    logic             vs_line, act_line, in_hs, in_burst, in_act, in_req, in_vs_sync;
    logic [9:0]       x_cur;
    logic [12:0]      bar_prod;
    logic [2:0]       bar_idx;
    logic [PIX_W-1:0] bar_luma, luma;
    logic [DAC_W:0]   luma_ext;
    logic [DAC_W-1:0] luma_code, code;
    logic             is_sync, is_act;

    // Raster geometry for the mode latched at the last frame start.
    always_comb begin
        hpos_last = pal_q ? P_HLST : N_HLST;
        vs_sync_e = pal_q ? P_VSSE : N_VSSE;
        line_last = pal_q ? P_LLST : N_LLST;
        vs_s      = pal_q ? P_VS_S : N_VS_S;
        vs_e      = pal_q ? P_VS_E : N_VS_E;
        act_lines = pal_q ? P_ACTL : N_ACTL;
    end

    // Horizontal/vertical counters; the mode only changes on the wrap into line 0.
    always_comb begin
        hpos_d = hpos_q + 10'd1;
        line_d = line_q;
        pal_d  = pal_q;
        if (hpos_q == hpos_last) begin
            hpos_d = '0;
            if (line_q == line_last) begin
                line_d = '0;
                pal_d  = pal_sel_i;
            end else begin
                line_d = line_q + 9'd1;
            end
        end
    end

    // Window decode for the current position.
    always_comb begin
        vs_line    = (line_q >= vs_s) && (line_q < vs_e);
        act_line   = line_q < act_lines;
        in_hs      = (hpos_q >= HS_S) && (hpos_q < HS_E);
        in_burst   = (hpos_q >= BU_S) && (hpos_q < BU_E);
        in_act     = (hpos_q >= ACT_S) && (hpos_q < ACT_E);
        in_req     = (hpos_q >= REQ_S) && (hpos_q < REQ_E);
        in_vs_sync = (hpos_q >= HS_S) && (hpos_q < vs_sync_e);
    end

    // Pixel request runs one cycle ahead of the active pixel so the source can register its answer.
    always_comb begin
        pix_req_o = (src_sel_i == 3'd0) && act_line && !vs_line && in_req;
        pix_x_o   = pix_req_o ? (hpos_q - REQ_S) : '0;
        pix_y_o   = pix_req_o ? line_q : '0;
    end

    // Luma source select and conversion to a saturated DAC code.
    always_comb begin
        x_cur    = hpos_q - ACT_S;
        bar_prod = {x_cur, 3'b000};
        bar_idx  = 3'(bar_prod / 13'(ACT_LEN));
        bar_luma = PIX_W'((BW'(3'd7 - bar_idx) * BW'(FULL)) / BW'(7));
        case (src_sel_i)
            3'd0:    luma = pix_luma_i;
            3'd1:    luma = '0;
            3'd2:    luma = '1;
            3'd3:    luma = (x_cur[4] ^ line_q[4]) ? '1 : '0;
            3'd4:    luma = PIX_W'(x_cur[9:2]);
            3'd5:    luma = bar_luma;
            default: luma = '0;
        endcase
        luma_ext  = BLACK_X + ((DAC_W+1)'(luma) << SH);
        luma_code = (luma_ext > WHITE_X) ? WHITE_C : luma_ext[DAC_W-1:0];
    end

    // Per-cycle code in priority order: vsync line, hsync, burst, picture, blank.
    always_comb begin
        code    = BLACK_C;
        is_sync = 1'b0;
        is_act  = 1'b0;
        if (vs_line) begin
            if (in_vs_sync) begin
                code    = SYNC_C;
                is_sync = 1'b1;
            end
        end else if (in_hs) begin
            code    = SYNC_C;
            is_sync = 1'b1;
        end else if (in_burst && !pal_q && color_en_i) begin
            case (hpos_q[1:0])
                2'd1:    code = BURST_HI;
                2'd3:    code = BURST_LO;
                default: code = BLACK_C;
            endcase
        end else if (act_line && in_act) begin
            code   = luma_code;
            is_act = 1'b1;
        end
        sample_d = (INVERT != 0) ? ~code : code;
        hsync_d  = is_sync;
        vsync_d  = vs_line;
        active_d = is_act;
        frame_d  = (hpos_q == '0) && (line_q == '0);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hpos_q   <= '0;
            line_q   <= '0;
            pal_q    <= 1'b0;
            sample_q <= SAMPLE_RST;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            active_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hpos_q   <= hpos_d;
            line_q   <= line_d;
            pal_q    <= pal_d;
            sample_q <= sample_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            frame_q  <= frame_d;
        end
    end

    assign sample_o = sample_q;
    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;
    assign active_o = active_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_composite_video_gen.sv
// Bench for composite_video_gen with shortened frames (full-length lines).
`timescale 1ns/1ps
module tb_composite_video_gen;

    localparam int NL = 910;
    localparam int PL = 916;
    localparam int F2 = 20 * NL;
    localparam int F3 = F2 + 24 * PL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pal_sel = 1'b0;
    logic        color_en = 1'b0;
    logic [2:0]  src_sel = 3'd1;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_luma = 8'h00;
    logic [11:0] sample;
    logic        hsync, vsync, active, frame;

    always #5 clk = ~clk;

    composite_video_gen #(
        .INVERT(0),
        .N_LINES(20), .N_VS_START(14), .N_VS_END(16), .N_ACT_LINES(12),
        .P_LINES(24), .P_VS_START(18), .P_VS_END(21), .P_ACT_LINES(15)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pal_sel_i(pal_sel), .color_en_i(color_en),
        .src_sel_i(src_sel), .pix_req_o(pix_req), .pix_x_o(pix_x), .pix_y_o(pix_y),
        .pix_luma_i(pix_luma), .sample_o(sample), .hsync_o(hsync), .vsync_o(vsync),
        .active_o(active), .frame_o(frame)
    );

    typedef struct {
        int          c;
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // External pixel source: answers each request one cycle later (odd columns white, even 8'h10).
    logic       pend_req = 1'b0;
    logic [9:0] pend_x = '0;
    always @(negedge clk) begin
        pix_luma = pend_req ? (pend_x[0] ? 8'hFF : 8'h10) : 8'h00;
        pend_req = pix_req;
        pend_x   = pix_x;
    end

    function automatic void push(input int c, input int kind, input logic [31:0] val, input string tag);
        exp_t e;
        int   i;
        e.c = c; e.kind = kind; e.val = val; e.tag = tag;
        i = q.size();
        while (i > 0 && q[i-1].c > c) i--;
        q.insert(i, e);
    endfunction

    // Sample-stage expectation for the code computed at absolute cycle t.
    task automatic es(input int t, input logic [11:0] s, input logic hs, input logic vs,
                      input logic act, input logic frm, input string tag);
        push(t + 1, 0, {16'b0, s, hs, vs, act, frm}, tag);
    endtask

    // Request-stage expectation at absolute cycle t.
    task automatic er(input int t, input logic req, input int px, input int py, input string tag);
        push(t, 1, {12'b0, req, 10'(px), 9'(py)}, tag);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.c < cyc) begin
                errors++;
                $error("FAIL %s slot %0d passed at cycle %0d", e.tag, e.c, cyc);
            end else begin
                obs = (e.kind == 0) ? {16'b0, sample, hsync, vsync, active, frame}
                                    : {12'b0, pix_req, pix_x, pix_y};
                assert (obs === e.val) else begin
                    errors++;
                    $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
                end
            end
        end
    end

    task automatic reset_checks(input string pfx);
        chk({pfx, "_sample"}, 32'(sample), 32'h0);
        chk({pfx, "_flags"}, {28'b0, hsync, vsync, active, frame}, 32'h0);
        chk({pfx, "_req"}, {12'b0, pix_req, pix_x, pix_y}, 32'h0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $error("FAIL %s never reached observed none expected %h", e.tag, e.val);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_checks("por");
        es(0, 12'h4CD, 0, 0, 0, 1, "f1_frame_pulse");
        es(1, 12'h4CD, 0, 0, 0, 0, "f1_frame_low");
        rst = 1'b0;

        // NTSC white line: sync, blank, picture boundaries.
        wait_cyc(NL); src_sel = 3'd2; color_en = 1'b0;
        es(NL+0,   12'h4CD, 0, 0, 0, 0, "l1_h0");
        es(NL+21,  12'h4CD, 0, 0, 0, 0, "l1_h21");
        es(NL+22,  12'h000, 1, 0, 0, 0, "l1_h22_sync");
        es(NL+88,  12'h000, 1, 0, 0, 0, "l1_h88_sync");
        es(NL+89,  12'h4CD, 0, 0, 0, 0, "l1_h89_noburst");
        es(NL+156, 12'h4CD, 0, 0, 0, 0, "l1_h156");
        es(NL+157, 12'hFFF, 0, 0, 1, 0, "l1_h157_white");
        es(NL+908, 12'hFFF, 0, 0, 1, 0, "l1_h908_white");
        es(NL+909, 12'h4CD, 0, 0, 0, 0, "l1_h909");

        // Burst phases and window edges.
        wait_cyc(2*NL); color_en = 1'b1;
        es(2*NL+22,  12'h000, 1, 0, 0, 0, "l2_h22_period");
        es(2*NL+89,  12'h5BD, 0, 0, 0, 0, "l2_burst89");
        es(2*NL+90,  12'h4CD, 0, 0, 0, 0, "l2_burst90");
        es(2*NL+91,  12'h3DD, 0, 0, 0, 0, "l2_burst91");
        es(2*NL+92,  12'h4CD, 0, 0, 0, 0, "l2_burst92");
        es(2*NL+121, 12'h5BD, 0, 0, 0, 0, "l2_burst121");
        es(2*NL+123, 12'h3DD, 0, 0, 0, 0, "l2_burst123");
        es(2*NL+125, 12'h4CD, 0, 0, 0, 0, "l2_after_burst");

        // External source: request timing and luma scaling/saturation.
        wait_cyc(3*NL); src_sel = 3'd0; color_en = 1'b0;
        er(3*NL+155, 0, 0,   0, "l3_req155");
        er(3*NL+156, 1, 0,   3, "l3_req156");
        er(3*NL+157, 1, 1,   3, "l3_req157");
        er(3*NL+907, 1, 751, 3, "l3_req907");
        er(3*NL+908, 0, 0,   0, "l3_req908");
        es(3*NL+156, 12'h4CD, 0, 0, 0, 0, "l3_ext156");
        es(3*NL+157, 12'h5CD, 0, 0, 1, 0, "l3_ext_x0");
        es(3*NL+158, 12'hFFF, 0, 0, 1, 0, "l3_ext_x1_sat");
        es(3*NL+908, 12'hFFF, 0, 0, 1, 0, "l3_ext_x751");

        wait_cyc(4*NL); src_sel = 3'd3;
        es(4*NL+157, 12'h4CD, 0, 0, 1, 0, "l4_chk_x0");
        es(4*NL+172, 12'h4CD, 0, 0, 1, 0, "l4_chk_x15");
        es(4*NL+173, 12'hFFF, 0, 0, 1, 0, "l4_chk_x16");
        es(4*NL+188, 12'hFFF, 0, 0, 1, 0, "l4_chk_x31");
        es(4*NL+189, 12'h4CD, 0, 0, 1, 0, "l4_chk_x32");

        wait_cyc(5*NL); src_sel = 3'd4;
        es(5*NL+257, 12'h65D, 0, 0, 1, 0, "l5_ramp_x100");
        es(5*NL+557, 12'hB0D, 0, 0, 1, 0, "l5_ramp_x400");
        es(5*NL+908, 12'hFFF, 0, 0, 1, 0, "l5_ramp_x751");

        wait_cyc(6*NL); src_sel = 3'd5;
        es(6*NL+157, 12'hFFF, 0, 0, 1, 0, "l6_bar_x0");
        es(6*NL+626, 12'hB9D, 0, 0, 1, 0, "l6_bar_x469");
        es(6*NL+627, 12'h94D, 0, 0, 1, 0, "l6_bar_x470");
        es(6*NL+908, 12'h4CD, 0, 0, 1, 0, "l6_bar_x751");

        wait_cyc(7*NL); src_sel = 3'd1;
        es(7*NL+500, 12'h4CD, 0, 0, 1, 0, "l7_black");

        // PAL requested mid-frame; must not take effect before the next frame.
        wait_cyc(8*NL); pal_sel = 1'b1; src_sel = 3'd2;

        wait_cyc(12*NL); src_sel = 3'd0;
        er(12*NL+300, 0, 0, 0, "l12_req_inactive");
        es(12*NL+500, 12'h4CD, 0, 0, 0, 0, "l12_inactive");

        wait_cyc(14*NL); color_en = 1'b1;
        er(14*NL+300, 0, 0, 0, "l14_req_vsync");
        es(14*NL+21,  12'h4CD, 0, 1, 0, 0, "l14_vs_h21");
        es(14*NL+22,  12'h000, 1, 1, 0, 0, "l14_vs_h22");
        es(14*NL+89,  12'h000, 1, 1, 0, 0, "l14_vs_noburst");
        es(14*NL+864, 12'h000, 1, 1, 0, 0, "l14_vs_h864");
        es(14*NL+865, 12'h4CD, 0, 1, 0, 0, "l14_vs_h865");

        wait_cyc(16*NL);
        es(16*NL+0,  12'h4CD, 0, 0, 0, 0, "l16_vs_end");
        es(16*NL+22, 12'h000, 1, 0, 0, 0, "l16_sync");
        es(16*NL+89, 12'h5BD, 0, 0, 0, 0, "l16_burst");
        es(19*NL+909, 12'h4CD, 0, 0, 0, 0, "l19_last_ntsc");

        // Second frame runs PAL geometry.
        wait_cyc(F2); src_sel = 3'd2;
        es(F2,             12'h4CD, 0, 0, 0, 1, "f2_frame_pulse");
        es(F2+NL+22,       12'h4CD, 0, 0, 0, 0, "f2_not_ntsc_period");
        es(F2+PL+22,       12'h000, 1, 0, 0, 0, "f2_pal_period");
        es(F2+2*PL+89,     12'h4CD, 0, 0, 0, 0, "f2_pal_noburst89");
        es(F2+2*PL+91,     12'h4CD, 0, 0, 0, 0, "f2_pal_noburst91");
        es(F2+13*PL+500,   12'hFFF, 0, 0, 1, 0, "f2_pal_act_line13");
        es(F2+18*PL+870,   12'h000, 1, 1, 0, 0, "f2_pal_vs_h870");
        es(F2+18*PL+871,   12'h4CD, 0, 1, 0, 0, "f2_pal_vs_h871");

        wait_cyc(F2+10*PL); pal_sel = 1'b0;

        wait_cyc(F3);
        es(F3,        12'h4CD, 0, 0, 0, 1, "f3_frame_pulse");
        es(F3+NL+22,  12'h000, 1, 0, 0, 0, "f3_ntsc_period");

        // Asynchronous reset in the middle of a picture line.
        wait_cyc(F3+3*NL); pal_sel = 1'b1;
        es(F3+3*NL+499, 12'hFFF, 0, 0, 1, 0, "pre_rst_active");
        wait_cyc(F3+3*NL+500);
        drain();
        #2 rst = 1'b1;
        #1 reset_checks("mid_rst");
        repeat (3) @(negedge clk);
        es(0,     12'h4CD, 0, 0, 0, 1, "post_rst_frame_pulse");
        es(1,     12'h4CD, 0, 0, 0, 0, "post_rst_frame_low");
        es(NL+16, 12'h4CD, 0, 0, 0, 0, "post_rst_h16");
        es(NL+22, 12'h000, 1, 0, 0, 0, "post_rst_ntsc_sync");
        rst = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
